ld_st_queue_ooo: RTL and testbench

Parametrised successor to the in-order load/store queue. It sits between dispatch/rename and the memory unit. Entries are accepted in program order over a valid/ready handshake. Stores issue only in order and only at ROB head. With LOAD_REORDER=1, loads may issue ahead of older, operand-stalled loads, but never past an older unissued store. Issue uses a valid/ready handshake, and the full DEPTH is usable.

---
 rtl/ld_st_queue_ooo.sv | 130 +++++++++++++
 tb/tb_ld_st_queue_ooo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ld_st_queue_ooo.sv
// Load/store queue between dispatch and the memory unit: in-order allocate,
// stores issue in order at ROB head, loads may optionally bypass stalled older loads.
module ld_st_queue_ooo #(
  parameter int DEPTH        = 16,
  parameter int LOAD_REORDER = 1,
  parameter int NUM_REGS     = 64,
  parameter int ROB_SIZE     = 16,
  parameter int XW           = 32,
  localparam int PR_W   = $clog2(NUM_REGS),
  localparam int ROB_W  = $clog2(ROB_SIZE),
  localparam int DATA_W = 1 + ROB_W + 2 * PR_W + XW,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_data,
  input  logic [NUM_REGS-1:0] phys_valid_vector,
  input  logic [ROB_W-1:0]  rob_head,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [DATA_W-1:0] iss_data,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full
);

  // Payload layout, MSB first: {is_store, rob_index, pr1, pr2, other fields}.
  localparam int STORE_BIT = DATA_W - 1;
  localparam int ROB_LSB   = 2 * PR_W + XW;
  localparam int PR1_LSB   = PR_W + XW;
  localparam int PR2_LSB   = XW;

  logic [AW:0]       r_head;
  logic [AW:0]       r_tail;
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_issued;
  logic [DATA_W-1:0] r_data [DEPTH];

  logic [DEPTH-1:0]  w_slot_store;
  logic [DEPTH-1:0]  w_slot_elig;
  logic [AW-1:0]     w_idx;
  logic [AW-1:0]     w_sel;
  logic              w_found;
  logic              w_stop;
  logic              w_enq_fire;
  logic              w_iss_fire;
  logic              w_reclaim;
  logic [AW-1:0]     w_head_slot;
  logic [AW-1:0]     w_tail_slot;

  assign w_head_slot = r_head[AW-1:0];
  assign w_tail_slot = r_tail[AW-1:0];

  assign count = r_tail - r_head;
  assign empty = (r_tail == r_head);
  assign full  = (w_tail_slot == w_head_slot) & (r_tail[AW] != r_head[AW]);

  // Both ports use valid/ready: a transfer happens on the cycle where valid and
  // ready are both high; valid may drop or change payload while ready is low.
  assign enq_ready  = ~full & ~flush;
  assign w_enq_fire = enq_valid & enq_ready;
  assign iss_valid  = w_found & ~flush;
  assign iss_data   = r_data[w_sel];
  assign w_iss_fire = iss_valid & iss_ready;
  assign w_reclaim  = r_valid[w_head_slot] & r_issued[w_head_slot];

  always_comb begin
    w_slot_store = '0;
    w_slot_elig  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_slot_store[i] = r_data[i][STORE_BIT];
      w_slot_elig[i]  = phys_valid_vector[r_data[i][PR1_LSB +: PR_W]] &
                        phys_valid_vector[r_data[i][PR2_LSB +: PR_W]] &
                        (~w_slot_store[i] | (r_data[i][ROB_LSB +: ROB_W] == rob_head));
    end
  end

  // Age-ordered scan from head; any unissued store is a hard barrier.
  always_comb begin
    w_found = 1'b0;
    w_stop  = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = w_head_slot + AW'(i);
      if (r_valid[w_idx] && !r_issued[w_idx] && !w_stop) begin
        if (w_slot_elig[w_idx]) begin
          w_found = 1'b1;
          w_sel   = w_idx;
          w_stop  = 1'b1;
        end
        if (w_slot_store[w_idx] || LOAD_REORDER == 0) w_stop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_valid  <= '0;
      r_issued <= '0;
    end else if (flush) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_valid  <= '0;
      r_issued <= '0;
    end else begin
      if (w_reclaim) begin
        r_valid[w_head_slot] <= 1'b0;
        r_head               <= r_head + (AW+1)'(1);
      end
      if (w_iss_fire) r_issued[w_sel] <= 1'b1;
      if (w_enq_fire) begin
        r_valid[w_tail_slot]  <= 1'b1;
        r_issued[w_tail_slot] <= 1'b0;
        r_tail                <= r_tail + (AW+1)'(1);
      end
    end
  end

  // Payload is qualified by r_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_enq_fire) r_data[w_tail_slot] <= enq_data;
  end

endmodule

// File: tb/tb_ld_st_queue_ooo.sv
// Directed bench for ld_st_queue_ooo: one reordering instance and one in-order
// instance driven by the same stimulus, DEPTH=4.
module tb_ld_st_queue_ooo;
  localparam int DW = 25;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          enq_valid = 1'b0;
  logic          iss_ready = 1'b0;
  logic [DW-1:0] enq_data = '0;
  logic [63:0]   pvv = '1;
  logic [3:0]    rob_head = '0;

  logic          enq_ready1, iss_valid1, empty1, full1;
  logic [DW-1:0] iss_data1;
  logic [2:0]    count1;
  logic          enq_ready0, iss_valid0, empty0, full0;
  logic [DW-1:0] iss_data0;
  logic [2:0]    count0;

  int n_cmp  = 0;
  int n_fail = 0;

  ld_st_queue_ooo #(.DEPTH(4), .LOAD_REORDER(1), .NUM_REGS(64), .ROB_SIZE(16), .XW(8)) u_ooo (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_ready(enq_ready1),
    .enq_data(enq_data), .phys_valid_vector(pvv), .rob_head(rob_head), .iss_valid(iss_valid1),
    .iss_ready(iss_ready), .iss_data(iss_data1), .count(count1), .empty(empty1), .full(full1));

  ld_st_queue_ooo #(.DEPTH(4), .LOAD_REORDER(0), .NUM_REGS(64), .ROB_SIZE(16), .XW(8)) u_ino (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_ready(enq_ready0),
    .enq_data(enq_data), .phys_valid_vector(pvv), .rob_head(rob_head), .iss_valid(iss_valid0),
    .iss_ready(iss_ready), .iss_data(iss_data0), .count(count0), .empty(empty0), .full(full0));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic st, input logic [3:0] rob,
                                       input logic [5:0] p1, input logic [5:0] p2,
                                       input logic [7:0] tag);
    return {st, rob, p1, p2, tag};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    if (iss_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid got=%0b exp=0", iss_valid1); end n_cmp++;
    if (count1 !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count1); end n_cmp++;
    if (empty1 !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%0b exp=1", empty1); end n_cmp++;
    if (full1 !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%0b exp=0", full1); end n_cmp++;
    if (enq_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready got=%0b exp=1", enq_ready1); end n_cmp++;
    if (count0 !== 3'd0) begin n_fail++; $display("FAIL reset_count_ino got=%0d exp=0", count0); end n_cmp++;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_full();
    iss_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      enq_valid = 1'b1;
      enq_data  = mk(1'b0, 4'(k), 6'd1, 6'd2, 8'(8'h10 + k));
      #1;
      if (enq_ready1 !== 1'b1) begin n_fail++; $display("FAIL fill_enq_ready k=%0d got=%0b exp=1", k, enq_ready1); end n_cmp++;
      if (count1 !== 3'(k)) begin n_fail++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, count1, k); end n_cmp++;
      step();
    end
    enq_data = mk(1'b0, 4'd9, 6'd1, 6'd2, 8'h99);
    #1;
    if (full1 !== 1'b1) begin n_fail++; $display("FAIL full_flag got=%0b exp=1", full1); end n_cmp++;
    if (count1 !== 3'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", count1); end n_cmp++;
    if (enq_ready1 !== 1'b0) begin n_fail++; $display("FAIL full_enq_ready got=%0b exp=0", enq_ready1); end n_cmp++;
    step();
    enq_valid = 1'b0;
    #1;
    if (count1 !== 3'd4) begin n_fail++; $display("FAIL refused_count got=%0d exp=4", count1); end n_cmp++;
    step();
    iss_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (iss_valid1 !== 1'b1) begin n_fail++; $display("FAIL drain_valid k=%0d got=%0b exp=1", k, iss_valid1); end n_cmp++;
      if (iss_data1 !== mk(1'b0, 4'(k), 6'd1, 6'd2, 8'(8'h10 + k))) begin n_fail++; $display("FAIL drain_data k=%0d got=%h exp_tag=%h", k, iss_data1, 8'(8'h10 + k)); end n_cmp++;
      if (iss_data0 !== mk(1'b0, 4'(k), 6'd1, 6'd2, 8'(8'h10 + k))) begin n_fail++; $display("FAIL drain_data_ino k=%0d got=%h exp_tag=%h", k, iss_data0, 8'(8'h10 + k)); end n_cmp++;
      step();
    end
    #1;
    if (iss_valid1 !== 1'b0) begin n_fail++; $display("FAIL drained_valid got=%0b exp=0", iss_valid1); end n_cmp++;
    if (count1 !== 3'd1) begin n_fail++; $display("FAIL drained_count got=%0d exp=1", count1); end n_cmp++;
    step();
    #1;
    if (count1 !== 3'd0) begin n_fail++; $display("FAIL drained_count2 got=%0d exp=0", count1); end n_cmp++;
    if (empty1 !== 1'b1) begin n_fail++; $display("FAIL drained_empty got=%0b exp=1", empty1); end n_cmp++;
    step();
  endtask

  task automatic test_reorder();
    logic [DW-1:0] a, b;
    a = mk(1'b0, 4'd1, 6'd7, 6'd1, 8'h0A);
    b = mk(1'b0, 4'd2, 6'd2, 6'd3, 8'h0B);
    flush = 1'b1;
    step();
    flush = 1'b0;
    pvv[7] = 1'b0;
    iss_ready = 1'b1;
    enq_valid = 1'b1;
    enq_data  = a;
    step();
    enq_data = b;
    #1;
    if (iss_valid1 !== 1'b0) begin n_fail++; $display("FAIL ro_a_stalled got=%0b exp=0", iss_valid1); end n_cmp++;
    step();
    enq_valid = 1'b0;
    #1;
    if (iss_valid1 !== 1'b1) begin n_fail++; $display("FAIL ro_b_valid got=%0b exp=1", iss_valid1); end n_cmp++;
    if (iss_data1 !== b) begin n_fail++; $display("FAIL ro_b_first got=%h exp=%h", iss_data1, b); end n_cmp++;
    if (iss_valid0 !== 1'b0) begin n_fail++; $display("FAIL ino_blocked got=%0b exp=0", iss_valid0); end n_cmp++;
    step();
    #1;
    if (iss_valid1 !== 1'b0) begin n_fail++; $display("FAIL ro_after_b got=%0b exp=0", iss_valid1); end n_cmp++;
    if (count1 !== 3'd2) begin n_fail++; $display("FAIL ro_count_hold got=%0d exp=2", count1); end n_cmp++;
    if (iss_valid0 !== 1'b0) begin n_fail++; $display("FAIL ino_still_blocked got=%0b exp=0", iss_valid0); end n_cmp++;
    step();
    pvv[7] = 1'b1;
    #1;
    if (iss_data1 !== a || iss_valid1 !== 1'b1) begin n_fail++; $display("FAIL ro_a_issue got=%h/%0b exp=%h/1", iss_data1, iss_valid1, a); end n_cmp++;
    if (iss_data0 !== a || iss_valid0 !== 1'b1) begin n_fail++; $display("FAIL ino_a_issue got=%h/%0b exp=%h/1", iss_data0, iss_valid0, a); end n_cmp++;
    step();
    #1;
    if (iss_valid1 !== 1'b0) begin n_fail++; $display("FAIL ro_done got=%0b exp=0", iss_valid1); end n_cmp++;
    if (count1 !== 3'd2) begin n_fail++; $display("FAIL ro_count_t5 got=%0d exp=2", count1); end n_cmp++;
    if (iss_data0 !== b || iss_valid0 !== 1'b1) begin n_fail++; $display("FAIL ino_b_issue got=%h/%0b exp=%h/1", iss_data0, iss_valid0, b); end n_cmp++;
    step();
    #1;
    if (count1 !== 3'd1) begin n_fail++; $display("FAIL ro_reclaim_a got=%0d exp=1", count1); end n_cmp++;
    if (count0 !== 3'd1) begin n_fail++; $display("FAIL ino_reclaim_a got=%0d exp=1", count0); end n_cmp++;
    step();
    #1;
    if (count1 !== 3'd0 || empty1 !== 1'b1) begin n_fail++; $display("FAIL ro_reclaim_b got=%0d/%0b exp=0/1", count1, empty1); end n_cmp++;
    if (count0 !== 3'd0) begin n_fail++; $display("FAIL ino_reclaim_b got=%0d exp=0", count0); end n_cmp++;
    iss_ready = 1'b0;
    step();
  endtask

  task automatic test_store_order();
    logic [DW-1:0] s, l;
    s = mk(1'b1, 4'd5, 6'd1, 6'd2, 8'h51);
    l = mk(1'b0, 4'd6, 6'd3, 6'd4, 8'h4C);
    rob_head  = 4'd3;
    iss_ready = 1'b1;
    enq_valid = 1'b1;
    enq_data  = s;
    step();
    enq_data = l;
    #1;
    if (iss_valid1 !== 1'b0) begin n_fail++; $display("FAIL st_not_head got=%0b exp=0", iss_valid1); end n_cmp++;
    step();
    enq_valid = 1'b0;
    #1;
    if (iss_valid1 !== 1'b0) begin n_fail++; $display("FAIL st_barrier got=%0b exp=0", iss_valid1); end n_cmp++;
    if (iss_valid0 !== 1'b0) begin n_fail++; $display("FAIL st_barrier_ino got=%0b exp=0", iss_valid0); end n_cmp++;
    if (count1 !== 3'd2) begin n_fail++; $display("FAIL st_count got=%0d exp=2", count1); end n_cmp++;
    step();
    rob_head = 4'd5;
    #1;
    if (iss_data1 !== s || iss_valid1 !== 1'b1) begin n_fail++; $display("FAIL st_issue got=%h/%0b exp=%h/1", iss_data1, iss_valid1, s); end n_cmp++;
    if (iss_data0 !== s) begin n_fail++; $display("FAIL st_issue_ino got=%h exp=%h", iss_data0, s); end n_cmp++;
    step();
    #1;
    if (iss_data1 !== l || iss_valid1 !== 1'b1) begin n_fail++; $display("FAIL st_then_load got=%h/%0b exp=%h/1", iss_data1, iss_valid1, l); end n_cmp++;
    if (iss_data0 !== l) begin n_fail++; $display("FAIL st_then_load_ino got=%h exp=%h", iss_data0, l); end n_cmp++;
    step();
    #1;
    if (iss_valid1 !== 1'b0 || count1 !== 3'd1) begin n_fail++; $display("FAIL st_after got=%0b/%0d exp=0/1", iss_valid1, count1); end n_cmp++;
    step();
    #1;
    if (count1 !== 3'd0) begin n_fail++; $display("FAIL st_empty got=%0d exp=0", count1); end n_cmp++;
    rob_head  = 4'd0;
    iss_ready = 1'b0;
    step();
  endtask

  task automatic test_flush();
    iss_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      enq_valid = 1'b1;
      enq_data  = mk(1'b0, 4'(k), 6'd1, 6'd2, 8'(8'h30 + k));
      step();
    end
    flush     = 1'b1;
    iss_ready = 1'b1;
    enq_data  = mk(1'b0, 4'd3, 6'd1, 6'd2, 8'h33);
    #1;
    if (iss_valid1 !== 1'b0) begin n_fail++; $display("FAIL flush_iss_valid got=%0b exp=0", iss_valid1); end n_cmp++;
    if (iss_valid0 !== 1'b0) begin n_fail++; $display("FAIL flush_iss_valid_ino got=%0b exp=0", iss_valid0); end n_cmp++;
    if (enq_ready1 !== 1'b0) begin n_fail++; $display("FAIL flush_enq_ready got=%0b exp=0", enq_ready1); end n_cmp++;
    if (count1 !== 3'd3) begin n_fail++; $display("FAIL flush_count_before got=%0d exp=3", count1); end n_cmp++;
    step();
    flush     = 1'b0;
    enq_valid = 1'b0;
    iss_ready = 1'b0;
    #1;
    if (count1 !== 3'd0 || empty1 !== 1'b1) begin n_fail++; $display("FAIL flush_after got=%0d/%0b exp=0/1", count1, empty1); end n_cmp++;
    if (iss_valid1 !== 1'b0) begin n_fail++; $display("FAIL flush_after_valid got=%0b exp=0", iss_valid1); end n_cmp++;
    if (count0 !== 3'd0) begin n_fail++; $display("FAIL flush_after_ino got=%0d exp=0", count0); end n_cmp++;
    step();
  endtask

  task automatic test_back_to_back_wrap();
    int exp_cnt;
    iss_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      enq_valid = 1'b1;
      enq_data  = mk(1'b0, 4'(k), 6'd1, 6'd2, 8'(8'h80 + k));
      exp_cnt   = (k < 2) ? k : 2;
      #1;
      if (count1 !== 3'(exp_cnt)) begin n_fail++; $display("FAIL wrap_count k=%0d got=%0d exp=%0d", k, count1, exp_cnt); end n_cmp++;
      if (enq_ready1 !== 1'b1) begin n_fail++; $display("FAIL wrap_enq_ready k=%0d got=%0b exp=1", k, enq_ready1); end n_cmp++;
      if (k >= 1) begin
        if (iss_valid1 !== 1'b1 || iss_data1 !== mk(1'b0, 4'(k-1), 6'd1, 6'd2, 8'(8'h80 + k - 1))) begin
          n_fail++; $display("FAIL wrap_order k=%0d got=%h/%0b exp_tag=%h", k, iss_data1, iss_valid1, 8'(8'h80 + k - 1));
        end
        n_cmp++;
        if (iss_data0 !== mk(1'b0, 4'(k-1), 6'd1, 6'd2, 8'(8'h80 + k - 1))) begin n_fail++; $display("FAIL wrap_order_ino k=%0d got=%h", k, iss_data0); end n_cmp++;
      end
      step();
    end
    enq_valid = 1'b0;
    #1;
    if (iss_data1 !== mk(1'b0, 4'd9, 6'd1, 6'd2, 8'h89)) begin n_fail++; $display("FAIL wrap_last got=%h exp_tag=89", iss_data1); end n_cmp++;
    if (count1 !== 3'd2) begin n_fail++; $display("FAIL wrap_last_count got=%0d exp=2", count1); end n_cmp++;
    step();
    iss_ready = 1'b0;
    enq_valid = 1'b1;
    enq_data  = mk(1'b0, 4'd0, 6'd1, 6'd2, 8'hF0);
    step();
    enq_valid = 1'b0;
    #1;
    if (iss_valid1 !== 1'b1 || count1 !== 3'd1) begin n_fail++; $display("FAIL pre_reset got=%0b/%0d exp=1/1", iss_valid1, count1); end n_cmp++;
    #1;
    rst = 1'b0;
    #1;
    if (iss_valid1 !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid got=%0b exp=0", iss_valid1); end n_cmp++;
    if (count1 !== 3'd0 || empty1 !== 1'b1) begin n_fail++; $display("FAIL async_reset_count got=%0d/%0b exp=0/1", count1, empty1); end n_cmp++;
    if (count0 !== 3'd0) begin n_fail++; $display("FAIL async_reset_count_ino got=%0d exp=0", count0); end n_cmp++;
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_full();
    test_reorder();
    test_store_order();
    test_flush();
    test_back_to_back_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
